// File: rtl/serial_pattern_detector.sv
// Serial pattern detector: shifts a bit stream into a window and compares it
// against programmable masked patterns, with a registered match pulse and a saturating count.
module serial_pattern_detector #(
    parameter int PAT_W   = 5,
    parameter int NUM_PAT = 2,
    parameter int CNT_W   = 8,
    parameter int SEL_W   = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               din,
    input  logic               din_valid,
    input  logic               overlap_en,
    input  logic               pat_wr,
    input  logic [SEL_W-1:0]   pat_sel,
    input  logic [PAT_W-1:0]   pat_data,
    input  logic [PAT_W-1:0]   pat_care,
    input  logic               pat_en_wr,
    output logic               match,
    output logic [NUM_PAT-1:0] match_id,
    output logic [CNT_W-1:0]   match_cnt,
    output logic [PAT_W-1:0]   window,
    output logic               primed
);

    localparam int FW = $clog2(PAT_W + 1);
    localparam logic [FW-1:0] FULL = FW'(PAT_W);

    logic [PAT_W-1:0]   window_q;
    logic [PAT_W-1:0]   window_nx;
    logic [FW-1:0]      fill_q;
    logic [FW-1:0]      fill_inc;
    logic [FW-1:0]      fill_nx;
    logic [PAT_W-1:0]   pat_q  [NUM_PAT];
    logic [PAT_W-1:0]   care_q [NUM_PAT];
    logic [NUM_PAT-1:0] en_q;
    logic [NUM_PAT-1:0] hits;
    logic               match_q;
    logic [NUM_PAT-1:0] id_q;
    logic [CNT_W-1:0]   cnt_q;

    // Compare against the window as it will look after this beat.
    always_comb begin
        window_nx = {window_q[PAT_W-2:0], din};
        fill_inc  = (fill_q == FULL) ? FULL : fill_q + 1'b1;
        hits      = '0;
        for (int k = 0; k < NUM_PAT; k++) begin
            if (din_valid && en_q[k] && (fill_inc == FULL) &&
                (((window_nx ^ pat_q[k]) & care_q[k]) == '0)) begin
                hits[k] = 1'b1;
            end
        end
        fill_nx = ((|hits) && !overlap_en) ? '0 : fill_inc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            window_q <= '0;
            fill_q   <= '0;
            match_q  <= 1'b0;
            id_q     <= '0;
            cnt_q    <= '0;
        end else if (clear) begin
            window_q <= '0;
            fill_q   <= '0;
            match_q  <= 1'b0;
            id_q     <= '0;
            cnt_q    <= '0;
        end else begin
            match_q <= |hits;
            id_q    <= hits;
            if (din_valid) begin
                window_q <= window_nx;
                fill_q   <= fill_nx;
            end
            if ((|hits) && (cnt_q != '1)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // Slots survive clear; selects beyond NUM_PAT match no slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_PAT; k++) begin
                pat_q[k]  <= '0;
                care_q[k] <= '1;
                en_q[k]   <= 1'b0;
            end
        end else if (pat_wr) begin
            for (int k = 0; k < NUM_PAT; k++) begin
                if (pat_sel == SEL_W'(k)) begin
                    pat_q[k]  <= pat_data;
                    care_q[k] <= pat_care;
                    en_q[k]   <= pat_en_wr;
                end
            end
        end
    end

    assign match     = match_q;
    assign match_id  = id_q;
    assign match_cnt = cnt_q;
    assign window    = window_q;
    assign primed    = (fill_q == FULL);

endmodule

// File: doc/serial_pattern_detector.md
Name: serial_pattern_detector

Overview:
Clocked successor to the fixed 5-input pattern-match block. It shifts a serial bit stream into a PAT_W-bit window and compares the window each beat against NUM_PAT runtime-programmable patterns, each with a don't-care mask. It reports a registered match pulse, a one-hot pattern ID and a saturating match count. Overlapping or non-overlapping detection is selectable. It sits between a serial data source and the status/interrupt logic.

Parameters:
PAT_W, 5, pattern and window width in bits (2..16)
NUM_PAT, 2, number of independent pattern slots (1..8)
CNT_W, 8, match counter width; the counter saturates at all-ones
SEL_W, 1, pattern-slot select width (>= clog2(NUM_PAT), minimum 1)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
clear  in  1  synchronous clear of window, fill count, counter and outputs; pattern slots are kept
din  in  1  serial data bit
din_valid  in  1  din is sampled this cycle
overlap_en  in  1  1 = overlapping detection, 0 = window restarts after a match
pat_wr  in  1  write strobe for one pattern slot
pat_sel  in  SEL_W  slot index for pat_wr
pat_data  in  PAT_W  pattern value; MSB = first-received bit
pat_care  in  PAT_W  care mask; 1 = compare this bit, 0 = don't-care
pat_en_wr  in  1  value written to the slot-enable bit by pat_wr
match  out  1  one-cycle registered match pulse
match_id  out  NUM_PAT  one-hot or multi-hot set of slots that matched
match_cnt  out  CNT_W  saturating count of match pulses
window  out  PAT_W  current shift window (debug)
primed  out  1  window holds at least PAT_W valid bits since the last reset, clear or restart

Behaviour:
- Reset values (rst_n=0, asynchronous): window=0, fill=0, primed=0, match=0, match_id=0, match_cnt=0, all slot patterns=0, care masks=all ones, slot enables=0.
- Shift on a din_valid=1 beat: window_next = {window[PAT_W-2:0], din}, so the oldest bit is in the MSB. The fill counter increments and saturates at PAT_W. primed = (fill==PAT_W).
- Compare is evaluated on window_next and fill_next during a din_valid beat. Slot k hits when en[k]=1, fill_next==PAT_W and ((window_next ^ pat[k]) & care[k])==0.
- Outputs are registered with one cycle of latency. In the cycle after the completing din_valid beat, match=|hits and match_id=hits. Otherwise match=0 and match_id=0.
- When din_valid=0, the window and fill hold, and match and match_id are 0 on the next cycle.
- Several slots may hit together. match_id shows all of them, match pulses once, and match_cnt increments by 1.
- match_cnt increments on each match pulse and holds at 2^CNT_W-1.
- overlap_en=1: fill stays at PAT_W after a match, so the next bit may produce another match.
- overlap_en=0: on a beat that hits, fill_next is forced to 0. The window contents still shift, but no match is possible until PAT_W further valid bits have arrived.
- Pattern write: when pat_wr=1, slot pat_sel is loaded with pat_data, pat_care and pat_en_wr at the clock edge. A din_valid beat in the same cycle compares against the old slot contents. pat_sel >= NUM_PAT is ignored.
- An all-zero care mask on an enabled slot matches every primed beat. This is legal.
- clear has priority over din_valid in the same cycle. The beat is dropped, and window, fill, match, match_id and match_cnt all go to 0.
- rst_n asserted mid-stream aborts immediately and returns everything to reset values. A pending match pulse is lost.
- changing overlap_en takes effect on the next din_valid beat.

Test Plan:
1. Defaults (PAT_W=5), slot0=10110 and slot1=11010, both enabled with care=11111, overlap_en=1; stream 1,0,1,1,0 -> match=1 and match_id=01 one cycle after the 5th beat; match_cnt=1; primed rises after beat 5.
2. Overlap: slot0=10101 care=11111; stream 1,0,1,0,1,0,1 with overlap_en=1 -> matches after beats 5 and 7, cnt=2. Same stream with overlap_en=0 -> one match only after beat 5, cnt=1.
3. Don't-care and multi-hit: slot0=10110 care=11111, slot1=10000 care=10000; stream 1,0,1,1,0 -> match_id=11, match single pulse, cnt=1.
4. Gaps: stream 1,0,1,1,0 with din_valid low for 3 cycles between bits 2 and 3 -> single match after the 5th valid beat, no spurious pulse during idle cycles.
5. Saturation with CNT_W=2: the 10110 pattern repeated 5 times non-overlapping -> match_cnt goes 1,2,3,3,3.
6. Priority and reset: clear asserted together with the completing 5th beat -> no match, cnt=0, window=0. rst_n pulsed low mid-stream -> all outputs 0 asynchronously and slot enables 0, so the following 10110 stream gives no match.
